// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) / divide (restoring)
// responder for the multicycle MIPS datapath. One iteration per clock, ITER
// iterations per operation, HI/LO written on entry to DONE with a one-cycle Done.
// Optional macro MULDIV_UNSIGNED_EN adds the Unsgn input (multu/divu semantics).
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clck,
    input  logic             rst_n,
    input  logic [1:0]       MulCtrl,
    input  logic [1:0]       DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             Unsgn,
`endif
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done,
    output logic             DivZeroOP
);

    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // datapath registers
    logic [CW-1:0]    cnt,   cnt_d;
    logic [WIDTH-1:0] mcand, mcand_d;
    logic [PW-1:0]    prod,  prod_d;
    logic [WIDTH-1:0] dvs,   dvs_d;
    logic [WIDTH-1:0] quo,   quo_d;
    logic [WIDTH-1:0] rem,   rem_d;
    logic             neg_q, neg_q_d;
    logic             neg_r, neg_r_d;
    logic             uns_q, uns_d;

    // next values of the registered outputs
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d, dz_d;

    logic             mul_start_c, div_start_c, div_zero_c, uns_c, last_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;

    assign mul_start_c = (MulCtrl == 2'b01);
    // multiply wins when both commands arrive together
    assign div_start_c = (DivCtrl == 2'b01) && !mul_start_c;
    assign div_zero_c  = (B == '0);
    assign last_c      = (cnt == CW'(ITER - 1));

`ifdef MULDIV_UNSIGNED_EN
    assign uns_c = Unsgn;
`else
    assign uns_c = 1'b0;
`endif

    // operand magnitudes for the divider; unsigned mode uses raw operands
    assign a_mag_c = (A[WIDTH-1] && !uns_c) ? -A : A;
    assign b_mag_c = (B[WIDTH-1] && !uns_c) ? -B : B;

    // Booth / add-shift step: upper WIDTH+1 bits accumulate, multiplier in the low half
    logic [WIDTH:0] up_c, mc_ext_c, sum_c;
    logic [PW-1:0]  booth_nxt_c;
    always_comb begin
        up_c     = prod[PW-1:WIDTH+1];
        mc_ext_c = {mcand[WIDTH-1] & ~uns_q, mcand};
        sum_c    = up_c;
        if (uns_q) begin
            if (prod[1]) sum_c = up_c + mc_ext_c;
            booth_nxt_c = {1'b0, sum_c, prod[WIDTH:1]};
        end else begin
            case (prod[1:0])
                2'b01:   sum_c = up_c + mc_ext_c;
                2'b10:   sum_c = up_c - mc_ext_c;
                default: sum_c = up_c;
            endcase
            booth_nxt_c = {sum_c[WIDTH], sum_c, prod[WIDTH:1]};
        end
    end

    // restoring division step on magnitudes plus final sign fix-up
    logic [WIDTH:0]   shift_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c, q_fix_c, r_fix_c;
    always_comb begin
        shift_c   = {rem, quo[WIDTH-1]};
        ge_c      = (shift_c >= {1'b0, dvs});
        rem_nxt_c = ge_c ? WIDTH'(shift_c - {1'b0, dvs}) : shift_c[WIDTH-1:0];
        quo_nxt_c = {quo[WIDTH-2:0], ge_c};
        q_fix_c   = neg_q ? -quo_nxt_c : quo_nxt_c;
        r_fix_c   = neg_r ? -rem_nxt_c : rem_nxt_c;
    end

    // state register
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic; only IDLE accepts a start
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (mul_start_c)      state_nxt = S_MUL;
                else if (div_start_c) state_nxt = div_zero_c ? S_DONE : S_DIV;
            end
            S_MUL, S_DIV: if (last_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output and datapath next values
    always_comb begin
        cnt_d   = cnt;
        mcand_d = mcand;
        prod_d  = prod;
        dvs_d   = dvs;
        quo_d   = quo;
        rem_d   = rem;
        neg_q_d = neg_q;
        neg_r_d = neg_r;
        uns_d   = uns_q;
        hi_d    = HI;
        lo_d    = LO;
        dz_d    = DivZeroOP;
        busy_d  = (state_nxt == S_MUL) || (state_nxt == S_DIV);
        done_d  = (state_nxt == S_DONE);
        case (state)
            S_IDLE: begin
                if (mul_start_c || div_start_c) begin
                    cnt_d   = '0;
                    mcand_d = A;
                    prod_d  = {{(WIDTH + 1){1'b0}}, B, 1'b0};
                    quo_d   = a_mag_c;
                    dvs_d   = b_mag_c;
                    rem_d   = '0;
                    neg_q_d = ~uns_c & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_r_d = ~uns_c & A[WIDTH-1];
                    uns_d   = uns_c;
                    dz_d    = div_start_c & div_zero_c;
                end
            end
            S_MUL: begin
                prod_d = booth_nxt_c;
                cnt_d  = CW'(cnt + 1'b1);
                if (last_c) begin
                    hi_d = booth_nxt_c[2*WIDTH:WIDTH+1];
                    lo_d = booth_nxt_c[WIDTH:1];
                end
            end
            S_DIV: begin
                quo_d = quo_nxt_c;
                rem_d = rem_nxt_c;
                cnt_d = CW'(cnt + 1'b1);
                if (last_c) begin
                    lo_d = q_fix_c;
                    hi_d = r_fix_c;
                end
            end
            default: ;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            prod      <= '0;
            dvs       <= '0;
            quo       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            uns_q     <= 1'b0;
            HI        <= '0;
            LO        <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivZeroOP <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            mcand     <= mcand_d;
            prod      <= prod_d;
            dvs       <= dvs_d;
            quo       <= quo_d;
            rem       <= rem_d;
            neg_q     <= neg_q_d;
            neg_r     <= neg_r_d;
            uns_q     <= uns_d;
            HI        <= hi_d;
            LO        <= lo_d;
            Busy      <= busy_d;
            Done      <= done_d;
            DivZeroOP <= dz_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with literal expectations plus a
// cycle-level behavioural model compared against the DUT every cycle.
module tb_mult_div_unit;

    logic        clck = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  MulCtrl = 2'b00;
    logic [1:0]  DivCtrl = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] HI, LO;
    logic        Busy, Done, DivZeroOP;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clck      (clck),
        .rst_n     (rst_n),
        .MulCtrl   (MulCtrl),
        .DivCtrl   (DivCtrl),
        .A         (A),
        .B         (B),
`ifdef MULDIV_UNSIGNED_EN
        .Unsgn     (1'b0),
`endif
        .HI        (HI),
        .LO        (LO),
        .Busy      (Busy),
        .Done      (Done),
        .DivZeroOP (DivZeroOP)
    );

    always #5 clck = ~clck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // reference arithmetic
    function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // returns {remainder, quotient}
    function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    logic [63:0] mul_ref, div_ref;
    assign mul_ref = f_mul(A, B);
    assign div_ref = f_div(A, B);

    // behavioural model: phase 0 idle, 1 busy, 2 done
    logic [1:0]  m_ph   = 2'd0;
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dz = 1'b0;

    always @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 2'd0; m_left <= 0; m_hi <= '0; m_lo <= '0;
            p_hi <= '0; p_lo <= '0; m_dz <= 1'b0;
        end else begin
            case (m_ph)
                2'd0: begin
                    if (MulCtrl == 2'b01) begin
                        p_hi <= mul_ref[63:32]; p_lo <= mul_ref[31:0];
                        m_left <= 32; m_ph <= 2'd1; m_dz <= 1'b0;
                    end else if (DivCtrl == 2'b01) begin
                        if (B == 32'h0) begin
                            m_dz <= 1'b1; m_ph <= 2'd2;
                        end else begin
                            p_hi <= div_ref[63:32]; p_lo <= div_ref[31:0];
                            m_left <= 32; m_ph <= 2'd1; m_dz <= 1'b0;
                        end
                    end
                end
                2'd1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_hi <= p_hi; m_lo <= p_lo; m_ph <= 2'd2;
                    end
                end
                default: m_ph <= 2'd0;
            endcase
        end
    end

    // every-cycle comparison against the model
    always @(negedge clck) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(Busy), 32'(m_ph == 2'd1));
            chk("cyc_done", 32'(Done), 32'(m_ph == 2'd2));
            chk("cyc_dz",   32'(DivZeroOP), 32'(m_dz));
            chk("cyc_hi",   HI, m_hi);
            chk("cyc_lo",   LO, m_lo);
        end
    end

    // one operation with literal expectations; inj >= 0 injects a divide pulse
    task automatic run_op(input string nm, input logic [1:0] mc, input logic [1:0] dc,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int inj);
        int n;
        @(negedge clck);
        MulCtrl = mc; DivCtrl = dc; A = a; B = b;
        @(negedge clck);
        MulCtrl = 2'b00; DivCtrl = 2'b00; A = $urandom; B = $urandom;
        chk({nm, "_dz_at_start"}, 32'(DivZeroOP), 32'(exp_dz));
        n = 0;
        while (Done !== 1'b1 && n < 100) begin
            if (n == inj) begin DivCtrl = 2'b01; B = 32'h0; end
            @(negedge clck);
            DivCtrl = 2'b00;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_hi"}, HI, exp_hi);
        chk({nm, "_lo"}, LO, exp_lo);
        chk({nm, "_dz"}, 32'(DivZeroOP), 32'(exp_dz));
        chk({nm, "_busy_at_done"}, 32'(Busy), 32'h0);
        @(negedge clck);
        chk({nm, "_single_done"}, 32'(Done), 32'h0);
        chk({nm, "_busy_after"}, 32'(Busy), 32'h0);
    endtask

    initial begin
        int dn;
        repeat (2) @(negedge clck);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_dz", 32'(DivZeroOP), 32'h0);
        chk_en = 1'b1;
        #2 rst_n = 1'b1;

        run_op("mul_7_m3",   2'b01, 2'b00, 32'd7, 32'hFFFFFFFD, 32, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1);
        run_op("mul_minneg", 2'b01, 2'b00, 32'h80000000, 32'h80000000, 32, 32'h40000000, 32'h0, 1'b0, -1);
        run_op("div_m7_2",   2'b00, 2'b01, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1);
        run_op("div_ovf",    2'b00, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32, 32'h0, 32'h80000000, 1'b0, -1);
        run_op("div_100_m7", 2'b00, 2'b01, 32'd100, 32'hFFFFFFF9, 32, 32'd2, 32'hFFFFFFF2, 1'b0, -1);
        run_op("mul_3_5",    2'b01, 2'b00, 32'd3, 32'd5, 32, 32'h0, 32'd15, 1'b0, -1);
        run_op("div_zero",   2'b00, 2'b01, 32'd5, 32'd0, 0, 32'h0, 32'd15, 1'b1, -1);
        run_op("mul_m1_m1",  2'b01, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h0, 32'd1, 1'b0, -1);

        // reset during iteration 10 of a multiply
        @(negedge clck);
        MulCtrl = 2'b01; A = 32'h00012345; B = 32'h00000777;
        @(negedge clck);
        MulCtrl = 2'b00;
        repeat (10) @(negedge clck);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hi", HI, 32'h0);
        chk("midrst_lo", LO, 32'h0);
        chk("midrst_busy", 32'(Busy), 32'h0);
        chk("midrst_done", 32'(Done), 32'h0);
        chk("midrst_dz", 32'(DivZeroOP), 32'h0);
        @(negedge clck);
        #2 rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clck);
            if (Done) dn++;
        end
        chk("midrst_no_done", 32'(dn), 32'h0);

        run_op("mul_2_3",    2'b01, 2'b00, 32'd2, 32'd3, 32, 32'h0, 32'd6, 1'b0, -1);
        run_op("arb_both",   2'b01, 2'b01, 32'd6, 32'd3, 32, 32'h0, 32'd18, 1'b0, 5);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
